sha256_asic_host: RTL
=====================

Name: sha256_asic_host

Overview:
- Host-side driver for the serial SHA-256 compression ASIC, which takes W words on in_w and state words on in_var, and returns results on out_var.
- Accepts one 256-bit initial state and one 512-bit message block in parallel.
- Serialises them onto the ASIC input buses in the fixed load order, then deserialises the ASIC's out_var stream into a 256-bit result.
- Sits between the system bus/controller and the ASIC core. It is the transmitter/collector for the ASIC's serial receiver.

Parameters:
- WORD_W, 32, width of in_w / in_var / out_var words.
- N_VARS, 8, state words loaded (A..H).
- N_W, 16, message words streamed in RUN.
- PRE_IDLE, 2, idle clocks before the first state word.
- OUT_LAT, 1, clocks between the last RUN word and the first valid out_var word.
- N_OUT, 8, result words collected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- init_state  in  256  A in [255:224] down to H in [31:0].
- block  in  512  word 0 in [511:480].
- busy  out  1  high in every state except IDLE.
- asic_in_w  out  32  drives the ASIC in_w.
- asic_in_var  out  32  drives the ASIC in_var.
- asic_out_var  in  32  from the ASIC out_var.
- digest  out  256  first collected word in [255:224].
- done  out  1  one-cycle pulse when digest is valid.

Behaviour:
- Reset (async assert, sync release) forces the following values:
  - state IDLE
  - all counters 0
  - asic_in_w = 0, asic_in_var = 0
  - digest = 0, done = 0, busy = 0
- FSM: IDLE -> PRE -> LOAD -> RUN -> WAIT -> COLLECT -> IDLE.
- IDLE:
  - On start=1, latch init_state and block into internal shift registers, then go to PRE.
  - The cycle after start, busy=1.
- PRE (PRE_IDLE cycles):
  - asic_in_var = 0.
  - asic_in_w = block word 0, held from PRE through the end of LOAD.
- LOAD (N_VARS cycles): asic_in_var = state word k on cycle k (A first). The state register shifts left one word per clock.
- RUN (N_W cycles):
  - asic_in_w = block word j on cycle j; the block register shifts one word per clock.
  - asic_in_var = 0.
- WAIT (OUT_LAT cycles):
  - asic_in_w = 0, asic_in_var = 0.
  - If OUT_LAT = 0, skip WAIT.
- COLLECT (N_OUT cycles): on each rising edge, shift asic_out_var into the LSB word of a capture register.
- Completion:
  - After the final capture, digest is updated in the same edge and done=1 for exactly one cycle, then return to IDLE.
  - digest holds until the next completion. It is not cleared on start.
- Latency: start to done = 1 + PRE_IDLE + N_VARS + N_W + OUT_LAT + N_OUT clocks (defaults: 36).
- start while busy: ignored, not queued.
- start on the same cycle done pulses: ignored, because the FSM is not yet in IDLE. start is accepted from the next cycle.
- Reset mid-operation: immediate abort to the reset values. A partial digest is discarded and the previous digest is lost.
- Counters are sized $clog2(max phase length + 1) and wrap only via explicit reload at each phase change.

Optional Feature:
- Macro: SHA256_ASIC_HOST_RESET_GEN_EN.
- Defined:
  - Adds output port asic_reset (1 bit, active-high).
  - asic_reset is asserted for the first PRE_IDLE cycles after a start is accepted (the PRE phase) and is 0 otherwise.
  - asic_reset is 1 while reset is asserted, so the ASIC is reset per block.
- Undefined: the port is absent. The ASIC is reset externally and PRE cycles are plain idle cycles.

Decomposition:
- Package sha256_asic_pkg holds:
  - the FSM state enum
  - WORD_W
  - the SHA-256 IV constants H0..H7 (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19)
- One sub-module, sha256_word_serdes: a generic N-word parallel-load shift register with serial out and serial-in capture. It is instantiated for state-out, block-out and digest-in.

Test Plan:
- IV load:
  - Stimulus: reset pulse low, then start with init_state = the IV constants and block word0 = 02000000.
  - Required: asic_in_var is 0 for 2 cycles, then 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19 on consecutive cycles, with asic_in_w = 02000000 throughout.
- RUN stream:
  - Stimulus: block words = 12300000 + j.
  - Required: asic_in_w steps 12300000..1230000F on the 16 RUN cycles, then 0.
- Collect:
  - Stimulus: a stub ASIC drives out_var = DEAD0000 + i on COLLECT cycle i.
  - Required: digest = DEAD0000..DEAD0007 (first in MSBs); done is high exactly 36 clocks after start, for 1 cycle.
- busy/start:
  - Stimulus: pulse start during LOAD, and again on the done cycle.
  - Required: both ignored, no state change; a start one cycle after done is accepted.
- Abort:
  - Stimulus: reset low mid-RUN.
  - Required: all outputs 0 immediately (async); the next start yields a full correct sequence.
- SHA256_ASIC_HOST_RESET_GEN_EN defined:
  - Required: asic_reset is high for exactly 2 cycles after start is accepted, aligned with PRE, and low for the rest of the run.

Source files
------------

// File: rtl/sha256_asic_pkg.sv
// Shared types and constants for the SHA-256 ASIC host driver.
package sha256_asic_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StLoad,
        StRun,
        StWait,
        StCollect
    } host_state_e;

    localparam logic [WORD_W-1:0] H0 = 32'h6a09e667;
    localparam logic [WORD_W-1:0] H1 = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] H2 = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] H3 = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] H4 = 32'h510e527f;
    localparam logic [WORD_W-1:0] H5 = 32'h9b05688c;
    localparam logic [WORD_W-1:0] H6 = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] H7 = 32'h5be0cd19;

    localparam logic [8*WORD_W-1:0] SHA256_IV = {H0, H1, H2, H3, H4, H5, H6, H7};

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sha256_asic_host_if.sv
// Controller-side and ASIC-side bus of the SHA-256 ASIC host driver.
interface sha256_asic_host_if #(
    parameter int unsigned N_VARS = 8,
    parameter int unsigned N_W    = 16,
    parameter int unsigned N_OUT  = 8
) ();
    import sha256_asic_pkg::*;

    logic                      start;
    logic [N_VARS*WORD_W-1:0]  init_state;
    logic [N_W*WORD_W-1:0]     block;
    logic                      busy;
    logic [N_OUT*WORD_W-1:0]   digest;
    logic                      done;
    logic [WORD_W-1:0]         asic_in_w;
    logic [WORD_W-1:0]         asic_in_var;
    logic [WORD_W-1:0]         asic_out_var;

    modport master (
        output start, init_state, block, asic_out_var,
        input  busy, digest, done, asic_in_w, asic_in_var
    );

    modport slave (
        input  start, init_state, block, asic_out_var,
        output busy, digest, done, asic_in_w, asic_in_var
    );

endinterface

// File: rtl/sha256_word_serdes.sv
// N-word shift register: parallel load, word-wide shift toward the MSB word with serial-in at the LSB.
module sha256_word_serdes #(
    parameter int unsigned N_WORDS = 8,
    parameter int unsigned WORD_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [N_WORDS*WORD_W-1:0]  par_in,
    input  logic                       shift,
    input  logic [WORD_W-1:0]          ser_in,
    output logic [N_WORDS*WORD_W-1:0]  par_out,
    output logic [WORD_W-1:0]          ser_out
);

    logic [N_WORDS*WORD_W-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= par_in;
        end else if (shift) begin
            data_q <= {data_q[N_WORDS*WORD_W-WORD_W-1:0], ser_in};
        end
    end

    assign par_out = data_q;
    assign ser_out = data_q[N_WORDS*WORD_W-1 -: WORD_W];

endmodule

// File: rtl/sha256_asic_host.sv
// Host driver for the serial SHA-256 ASIC: streams state/block words out, collects the result.
// Optional macro SHA256_ASIC_HOST_RESET_GEN_EN adds a per-block asic_reset output.
module sha256_asic_host
    import sha256_asic_pkg::*;
#(
    parameter int unsigned PRE_IDLE = 2,
    parameter int unsigned OUT_LAT  = 1,
    parameter int unsigned N_VARS   = 8,
    parameter int unsigned N_W      = 16,
    parameter int unsigned N_OUT    = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef SHA256_ASIC_HOST_RESET_GEN_EN
    output logic asic_reset,
`endif
    sha256_asic_host_if.slave bus
);

    localparam int unsigned MaxLen = max2(max2(max2(PRE_IDLE, N_VARS), max2(N_W, OUT_LAT)), N_OUT);
    localparam int unsigned CntW   = $clog2(MaxLen + 1);

    host_state_e              state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                     done_q, done_d;
    logic [N_OUT*WORD_W-1:0]  digest_q, digest_d;

    logic                     accept, st_shift, blk_shift, cap_shift;
    logic [N_VARS*WORD_W-1:0] st_par;
    logic [N_W*WORD_W-1:0]    blk_par;
    logic [N_OUT*WORD_W-1:0]  cap_par;
    logic [WORD_W-1:0]        st_ser, blk_ser, cap_ser;
    logic                     unused_serdes;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            digest_q <= digest_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        digest_d  = digest_q;
        accept    = 1'b0;
        st_shift  = 1'b0;
        blk_shift = 1'b0;
        cap_shift = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = (PRE_IDLE != 0) ? StPre : StLoad;
                end
            end
            StPre: begin
                cnt_d = cnt_inc;
                if (cnt_q == CntW'(PRE_IDLE - 1)) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                st_shift = 1'b1;
                cnt_d    = cnt_inc;
                if (cnt_q == CntW'(N_VARS - 1)) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                blk_shift = 1'b1;
                cnt_d     = cnt_inc;
                if (cnt_q == CntW'(N_W - 1)) begin
                    cnt_d   = '0;
                    state_d = (OUT_LAT != 0) ? StWait : StCollect;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (cnt_q == CntW'(OUT_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                // One extra cycle at cnt == N_OUT carries the done pulse, so start is ignored there.
                if (cnt_q == CntW'(N_OUT)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cap_shift = 1'b1;
                    cnt_d     = cnt_inc;
                    if (cnt_q == CntW'(N_OUT - 1)) begin
                        done_d   = 1'b1;
                        digest_d = {cap_par[(N_OUT-1)*WORD_W-1:0], bus.asic_out_var};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    sha256_word_serdes #(.N_WORDS(N_VARS), .WORD_W(WORD_W)) u_state_out (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .par_in  (bus.init_state),
        .shift   (st_shift),
        .ser_in  ('0),
        .par_out (st_par),
        .ser_out (st_ser)
    );

    sha256_word_serdes #(.N_WORDS(N_W), .WORD_W(WORD_W)) u_block_out (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .par_in  (bus.block),
        .shift   (blk_shift),
        .ser_in  ('0),
        .par_out (blk_par),
        .ser_out (blk_ser)
    );

    sha256_word_serdes #(.N_WORDS(N_OUT), .WORD_W(WORD_W)) u_digest_in (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .par_in  ('0),
        .shift   (cap_shift),
        .ser_in  (bus.asic_out_var),
        .par_out (cap_par),
        .ser_out (cap_ser)
    );

    assign unused_serdes = ^{st_par, blk_par, cap_par[N_OUT*WORD_W-1 -: WORD_W], cap_ser};

    // Block word 0 sits on in_w from PRE through LOAD; the block register only moves in RUN.
    assign bus.asic_in_w   = (state_q inside {StPre, StLoad, StRun}) ? blk_ser : '0;
    assign bus.asic_in_var = (state_q == StLoad) ? st_ser : '0;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.digest      = digest_q;

`ifdef SHA256_ASIC_HOST_RESET_GEN_EN
    assign asic_reset = !reset || (state_q == StPre);
`endif

endmodule
